// File: rtl/qos_vc_arbiter.sv
// qos_vc_arbiter: weighted round-robin consumer of four VC FIFOs.
// The arbiter pops one non-empty VC per cycle. The popped word is registered and then
// pushed to one of four destination FIFOs, picked by the word's two MSBs.
// Pops stop while any destination FIFO reports almost_full.
module qos_vc_arbiter #(
    parameter int DATA_W = 12,
    parameter int NUM_VC = 4,
    parameter int W_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_VC*DATA_W-1:0]   vc_data,
    input  logic [NUM_VC*W_BITS-1:0]   weights,
    input  logic [NUM_VC-1:0]          out_almost_full,
    output logic [NUM_VC-1:0]          vc_pop,
    output logic [NUM_VC-1:0]          out_push,
    output logic [DATA_W-1:0]          out_data,
    output logic                       idle
);

    // Arbitration state: current VC pointer and number of services granted to it.
    logic [1:0]        cur;
    logic [W_BITS-1:0] cnt;
    logic [1:0]        cur_nxt;
    logic [W_BITS-1:0] cnt_nxt;

    // Decision results for this cycle.
    logic              stall;
    logic [1:0]        pick;
    logic              pick_vld;
    logic              found;
    logic [1:0]        cand;

    // Pipeline: stage 1 holds the popped index, stage 2 holds the captured word.
    logic [1:0]        sel_p1;
    logic              vld_p1;
    logic              vld_p2;

    // A weight field of zero grants one service, the same as a weight of one.
    function automatic logic [W_BITS-1:0] eff_weight(
        input logic [NUM_VC*W_BITS-1:0] wv,
        input logic [1:0]               idx
    );
        logic [W_BITS-1:0] w;
        w = wv[idx*W_BITS +: W_BITS];
        return (w == '0) ? W_BITS'(1) : w;
    endfunction

    function automatic logic [NUM_VC-1:0] onehot(input logic [1:0] idx);
        logic [NUM_VC-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Weighted round-robin decision. The search wraps all the way back to cur, so that a
    // lone non-empty VC is granted again and its count restarts at 1.
    always_comb begin
        stall    = |out_almost_full;
        pick     = cur;
        pick_vld = 1'b0;
        cur_nxt  = cur;
        cnt_nxt  = cnt;
        found    = 1'b0;
        cand     = cur;
        if (!stall) begin
            if (!vc_empty[cur] && (cnt < eff_weight(weights, cur))) begin
                pick_vld = 1'b1;
                cnt_nxt  = cnt + W_BITS'(1);
            end else begin
                cnt_nxt = '0;
                for (int k = 1; k <= 4; k++) begin
                    cand = cur + 2'(k);
                    if (!found && !vc_empty[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    pick_vld = 1'b1;
                    cur_nxt  = pick;
                    cnt_nxt  = W_BITS'(1);
                end
            end
        end
    end

    // Pop strobe; forced low while reset is held so that nothing leaves a VC FIFO.
    always_comb begin
        vc_pop = '0;
        if (pick_vld && !reset) begin
            vc_pop = onehot(pick);
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= '0;
            cnt <= '0;
        end else begin
            cur <= cur_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Stage 1: remember which VC was popped; its word appears on vc_data next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= |vc_pop;
        end
        sel_p1 <= pick;
    end

    // Stage 2: capture the popped word. out_data holds its value between pushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data <= vc_data[sel_p1*DATA_W +: DATA_W];
            end
        end
    end

    // Route the captured word by its two MSBs.
    always_comb begin
        out_push = '0;
        if (vld_p2) begin
            out_push = onehot(out_data[DATA_W-1 -: 2]);
        end
    end

    // Idle flag: no data is waiting in any VC and no word is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle <= 1'b1;
        end else begin
            idle <= (&vc_empty) & ~vld_p1 & ~vld_p2 & ~(|vc_pop);
        end
    end

endmodule

// File: tb/tb_qos_vc_arbiter.sv
// Directed testbench for qos_vc_arbiter. It models the four VC FIFOs with queues.
// Expected pops and pushes go into scoreboards when words are loaded.
module tb_qos_vc_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vc_empty;
    logic [47:0] vc_data;
    logic [15:0] weights;
    logic [3:0]  out_almost_full;
    logic [3:0]  vc_pop;
    logic [3:0]  out_push;
    logic [11:0] out_data;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit bp     = 1'b0;

    logic [11:0] vcq [4][$];
    int          exp_pop_q[$];
    logic [11:0] exp_word_q[$];
    int          lat_q[$];
    logic [3:0]  pop_now;

    int order [32] = '{0,0,1,1,1,2,3, 0,0,1,1,1,2,3, 0,0,1,1,2,3, 0,0,2,3, 2,3,2,3,2,3,2,3};
    int per [4];

    qos_vc_arbiter #(.DATA_W(12), .NUM_VC(4), .W_BITS(4)) dut (
        .clk(clk),
        .reset(reset),
        .vc_empty(vc_empty),
        .vc_data(vc_data),
        .weights(weights),
        .out_almost_full(out_almost_full),
        .vc_pop(vc_pop),
        .out_push(out_push),
        .out_data(out_data),
        .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Check at the falling edge, then move one clock forward and model the VC FIFO reads.
    task tick;
        logic [11:0] w;
        @(negedge clk);
        if (vc_pop !== 4'b0000) begin
            chk("pop_onehot", $countones(vc_pop), 1);
            if (exp_pop_q.size() == 0) chk("pop_unexpected", vc_pop, 0);
            else chk("pop_order", vc_pop, oh(2'(exp_pop_q.pop_front())));
            lat_q.push_back(cyc);
        end
        if (bp) chk("pop_in_stall", vc_pop, 0);
        if (out_push !== 4'b0000) begin
            if (exp_word_q.size() == 0) begin
                chk("push_unexpected", out_push, 0);
            end else begin
                w = exp_word_q.pop_front();
                chk("push_data", out_data, w);
                chk("push_route", out_push, oh(w[11:10]));
                if (lat_q.size() != 0) chk("push_latency", cyc, lat_q.pop_front() + 2);
            end
        end
        pop_now = vc_pop;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pop_now[i] && vcq[i].size() != 0) vc_data[i*12 +: 12] = vcq[i].pop_front();
            vc_empty[i] = (vcq[i].size() == 0);
        end
    endtask

    task load(input int v, input logic [11:0] w);
        vcq[v].push_back(w);
        vc_empty[v] = 1'b0;
    endtask

    task expect_word(input int v, input logic [11:0] w);
        exp_pop_q.push_back(v);
        exp_word_q.push_back(w);
    endtask

    task wait_idle(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (!(idle === 1'b1 && exp_word_q.size() == 0) && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, (n < max_cycles), 1);
    endtask

    initial begin
        logic [11:0] w;
        reset           = 1'b1;
        vc_empty        = 4'hF;
        vc_data         = '0;
        weights         = 16'h1111;
        out_almost_full = 4'h0;

        // Reset held with VC0 non-empty: everything stays cleared.
        tick();
        load(0, 12'h4AB);
        expect_word(0, 12'h4AB);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_vc_pop", vc_pop, 0);
            chk("rst_out_push", out_push, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_idle", idle, 1);
            tick();
        end
        reset = 1'b0;
        #1;
        chk("first_pop_after_reset", vc_pop, 4'b0001);
        tick();
        wait_idle(20, "t1_idle_timeout");

        // Single VC, three words: fixed two-cycle latency and MSB routing.
        weights = 16'h1111;
        load(2, 12'h8A5); expect_word(2, 12'h8A5);
        load(2, 12'h123); expect_word(2, 12'h123);
        load(2, 12'hC00); expect_word(2, 12'hC00);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_pop_vc2", vc_pop, 4'b0100);
            tick();
        end
        #1;
        chk("t2_busy", idle, 0);
        wait_idle(20, "t2_idle_timeout");
        chk("t2_hold_data", out_data, 12'hC00);
        chk("t2_no_push", out_push, 0);

        // Weighted round-robin over 32 words, with a 5-cycle stall in the middle.
        reset   = 1'b1;
        weights = 16'h0132;
        per     = '{0, 0, 0, 0};
        for (int n = 0; n < 32; n++) begin
            w = {2'(order[n] + per[order[n]]), 2'(order[n]), 8'(per[order[n]])};
            per[order[n]]++;
            load(order[n], w);
            expect_word(order[n], w);
        end
        tick();
        reset = 1'b0;
        lat_q.delete();
        repeat (6) tick();
        bp              = 1'b1;
        out_almost_full = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i < 2) chk("bp_inflight_push", (out_push !== 4'b0000), 1);
            if (i == 2) chk("bp_drained", out_push, 0);
            tick();
        end
        bp              = 1'b0;
        out_almost_full = 4'b0000;
        #1;
        chk("bp_resume", (vc_pop !== 4'b0000), 1);
        wait_idle(80, "t3_idle_timeout");
        chk("t3_all_popped", exp_pop_q.size(), 0);

        // Wrap from cur=3 past empty VCs; weight field 0 acts as 1.
        weights = 16'h0000;
        load(1, 12'h1A1); load(1, 12'h9B2); load(2, 12'hE63);
        expect_word(1, 12'h1A1);
        expect_word(2, 12'hE63);
        expect_word(1, 12'h9B2);
        #1;
        chk("wrap_first_vc1", vc_pop, 4'b0010);
        wait_idle(20, "t4_idle_timeout");

        // Reset the cycle after a pop: that word is never pushed, and arbitration restarts at VC0.
        weights = 16'h2111;
        load(3, 12'hFF1); load(3, 12'h3F2);
        exp_pop_q.push_back(3);
        #1;
        chk("t5_pop_vc3", vc_pop, 4'b1000);
        tick();
        reset = 1'b1;
        lat_q.delete();
        load(0, 12'h0C3);
        #1;
        chk("t5_rst_no_pop", vc_pop, 0);
        tick();
        reset = 1'b0;
        expect_word(0, 12'h0C3);
        expect_word(3, 12'h3F2);
        #1;
        chk("t5_restart_vc0", vc_pop, 4'b0001);
        wait_idle(20, "t5_idle_timeout");
        repeat (3) tick();
        chk("final_idle", idle, 1);
        chk("final_pops_consumed", exp_pop_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
